// File: rtl/slow_tick_pkg.sv
// Shared types and default sizing for the slow-clock monitor.
package slow_tick_pkg;

    localparam int DEFAULT_CNT_W   = 26;
    localparam int DEFAULT_TIMEOUT = 27000002;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        LOST       = 2'd2
    } mon_state_e;

endpackage

// File: rtl/sync_ff.sv
// Parameterised-depth, reset-to-0 flop chain for bringing a single async bit into clk_in.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/slow_tick_monitor.sv
// Turns an async slow clock into clk_in-domain rise/fall enables, measures its period
// and flags loss of the slow clock.
module slow_tick_monitor
    import slow_tick_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             slow_in,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             lost,
    output logic [15:0]      edge_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic             s;
    logic             s_q;
    logic             rise;
    logic             fall;
    mon_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      edge_cnt;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .d        (slow_in),
        .q        (s)
    );

    assign rise = s & ~s_q;
    assign fall = ~s & s_q;

    // Edge detect and tick outputs; edge_count keeps running in every state.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            s_q       <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
            edge_cnt  <= '0;
        end else begin
            s_q       <= s;
            tick_rise <= rise;
            tick_fall <= fall;
            if (rise) begin
                edge_cnt <= edge_cnt + 16'd1;
            end
        end
    end

    assign edge_count = edge_cnt;

    // A rise always wins over the timeout on the same cycle. The first rise after
    // reset or loss only arms the counter; the next one yields a period.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state        <= WAIT_FIRST;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            lost         <= 1'b0;
        end else begin
            case (state)
                WAIT_FIRST, MEASURE: begin
                    if (rise) begin
                        if (state == MEASURE) begin
                            period       <= cnt + 1'b1;
                            period_valid <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= MEASURE;
                    end else if (cnt == CNT_LAST) begin
                        state        <= LOST;
                        lost         <= 1'b1;
                        period_valid <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOST: begin
                    if (rise) begin
                        lost  <= 1'b0;
                        cnt   <= '0;
                        state <= MEASURE;
                    end
                end
                default: begin
                    state <= WAIT_FIRST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slow_tick_monitor.sv
// Randomised bench for slow_tick_monitor against a timestamp-based reference model.
module tb_slow_tick_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 12;
    localparam int TIMEOUT     = 50;

    logic             clk_in   = 1'b0;
    logic             reset_in = 1'b1;
    logic             slow_in  = 1'b0;
    logic             tick_rise;
    logic             tick_fall;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             lost;
    logic [15:0]      edge_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: samples of slow_in per clk_in edge since reset release,
    // plus the edge index of the last rise (or of the release itself).
    bit hist[$];
    int m_cyc;
    int last_ref;
    bit armed;
    bit m_lost;
    bit m_valid;
    bit m_rise;
    bit m_fall;
    int m_period;
    int m_edges;

    always #5 clk_in = ~clk_in;

    slow_tick_monitor #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .slow_in      (slow_in),
        .tick_rise    (tick_rise),
        .tick_fall    (tick_fall),
        .period       (period),
        .period_valid (period_valid),
        .lost         (lost),
        .edge_count   (edge_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit sample_at(input int e);
        if (e >= 1 && e <= hist.size()) return hist[e-1];
        return 1'b0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_cyc    = 0;
        last_ref = 0;
        armed    = 1'b0;
        m_lost   = 1'b0;
        m_valid  = 1'b0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_period = 0;
        m_edges  = 0;
    endtask

    task automatic model_edge(input bit v);
        bit now_s;
        bit prev_s;
        m_cyc++;
        hist.push_back(v);
        now_s  = sample_at(m_cyc - SYNC_STAGES);
        prev_s = sample_at(m_cyc - SYNC_STAGES - 1);
        m_rise = now_s & ~prev_s;
        m_fall = ~now_s & prev_s;
        if (m_rise) begin
            m_edges = (m_edges + 1) & 16'hFFFF;
            if (armed) begin
                m_period = m_cyc - last_ref;
                m_valid  = 1'b1;
            end
            armed    = 1'b1;
            m_lost   = 1'b0;
            last_ref = m_cyc;
        end else if (!m_lost && (m_cyc - last_ref == TIMEOUT)) begin
            m_lost  = 1'b1;
            m_valid = 1'b0;
            armed   = 1'b0;
        end
    endtask

    task automatic check_all();
        check_eq("tick_rise",    32'(tick_rise),    32'(m_rise));
        check_eq("tick_fall",    32'(tick_fall),    32'(m_fall));
        check_eq("period",       32'(period),       32'(m_period));
        check_eq("period_valid", 32'(period_valid), 32'(m_valid));
        check_eq("lost",         32'(lost),         32'(m_lost));
        check_eq("edge_count",   32'(edge_count),   32'(m_edges));
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge(slow_in);
        #1;
        check_all();
    endtask

    task automatic run(input int n, input bit v);
        slow_in = v;
        for (int i = 0; i < n; i++) step();
    endtask

    // Outputs must clear while reset is still held, before any clock edge.
    task automatic do_reset(input bit level);
        slow_in  = level;
        reset_in = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk_in);
        reset_in = 1'b1;
    endtask

    int rise_seen_at;

    initial begin
        #2;
        do_reset(1'b0);

        run(5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run(5, 1'b1);
            run(5, 1'b0);
        end
        check_eq("sq10_period", 32'(period), 32'd10);
        check_eq("sq10_valid",  32'(period_valid), 32'd1);

        do_reset(1'b0);
        run(TIMEOUT - 1, 1'b0);
        check_eq("lost_early", 32'(lost), 32'd0);
        run(1, 1'b0);
        check_eq("lost_at_to", 32'(lost), 32'd1);
        check_eq("lost_valid", 32'(period_valid), 32'd0);
        run(10, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run(5, 1'b1);
            run(5, 1'b0);
        end
        check_eq("relock_lost",   32'(lost), 32'd0);
        check_eq("relock_period", 32'(period), 32'd10);

        for (int i = 0; i < 3; i++) begin
            run(TIMEOUT / 2, 1'b1);
            run(TIMEOUT / 2, 1'b0);
        end
        check_eq("edge_to_period", 32'(period), 32'(TIMEOUT));
        check_eq("edge_to_lost",   32'(lost), 32'd0);

        m_edges = 16'hFFFE;
        force dut.edge_cnt = 16'hFFFE;
        step();
        release dut.edge_cnt;
        run(5, 1'b1);
        check_eq("wrap_ffff", 32'(edge_count), 32'h0000FFFF);
        run(5, 1'b0);
        run(5, 1'b1);
        check_eq("wrap_0000", 32'(edge_count), 32'h00000000);
        run(5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run($urandom_range(1, 30), 1'b1);
            run($urandom_range(1, 60), 1'b0);
        end

        run(7, 1'b1);
        do_reset(1'b1);
        rise_seen_at = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (tick_rise && rise_seen_at == 0) rise_seen_at = i;
        end
        check_eq("rst_rise_cycle", 32'(rise_seen_at), 32'(SYNC_STAGES + 1));
        check_eq("rst_valid",      32'(period_valid), 32'd0);
        run(10, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/slow_tick_monitor.md
# slow_tick_monitor

Receive-side companion to the team's clock divider. Takes the divided slow clock (or any slow external square wave) as an asynchronous input, brings it into the `clk_in` domain, and emits single-cycle rise/fall enable pulses for fast-domain logic in place of a gated clock. It also measures the slow-clock period in `clk_in` cycles and flags loss of the slow clock with a watchdog.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth; minimum 2.
- `CNT_W`, default 26: period counter width.
- `TIMEOUT`, default 27000002: `clk_in` cycles without a rise before declaring loss; must satisfy 2 ≤ `TIMEOUT` < 2^`CNT_W`.
- `clk_in` in 1: fast clock. All logic runs on its rising edge.
- `reset_in` in 1: reset, asynchronous, active-low.
- `slow_in` in 1: asynchronous slow clock to monitor.
- `tick_rise` out 1: one-cycle pulse per detected rising edge of `slow_in`.
- `tick_fall` out 1: one-cycle pulse per detected falling edge of `slow_in`.
- `period` out `CNT_W`: last measured rise-to-rise interval, in `clk_in` cycles.
- `period_valid` out 1: `period` holds a measurement taken since the last reset or loss.
- `lost` out 1: watchdog expired; no rise seen for `TIMEOUT` cycles.
- `edge_count` out 16: number of detected rises; wraps from 0xFFFF to 0.

## Operation
- Synchronizer:
  - `slow_in` passes through `SYNC_STAGES` flops, all reset to 0.
  - Its output `s` feeds a history flop `s_q`, also reset to 0.
  - Rise = `s & ~s_q`. Fall = `~s & s_q`.
- States: WAIT_FIRST, MEASURE, LOST. Reset state is WAIT_FIRST.
- WAIT_FIRST:
  - A rise clears `cnt` to 0 and moves to MEASURE.
  - `cnt` increments each cycle; `cnt` = `TIMEOUT`-1 with no rise moves to LOST.
- MEASURE, on a rise:
  - `period` ← `cnt`+1 and `period_valid` ← 1.
  - `cnt` ← 0; stay in MEASURE.
- MEASURE, otherwise: `cnt` increments; `cnt` = `TIMEOUT`-1 moves to LOST.
- Entering LOST: `lost` ← 1 and `period_valid` ← 0; `period` keeps its last value.
- LOST, on a rise: `lost` ← 0, `cnt` ← 0, move to MEASURE. `period_valid` stays 0 until the next rise.
- A rise on the same cycle `cnt` reaches `TIMEOUT`-1 counts as a rise; the timeout is not taken.
- `tick_rise`, `tick_fall` and `edge_count` operate in every state, including LOST.
- Reset values: all outputs 0 and `cnt` 0.
- Reset mid-operation:
  - Immediate asynchronous clear of all state.
  - If `slow_in` is high at reset release, a rise is reported `SYNC_STAGES`+1 cycles later and only arms measurement.

## Timing
- `tick_rise`/`tick_fall` are registered.
- A `slow_in` transition that meets setup at edge k shows the pulse in the cycle after edge k+`SYNC_STAGES`. With default depth, latency is 3 cycles.
- Each pulse lasts exactly one `clk_in` cycle. A `slow_in` pulse shorter than one `clk_in` cycle may be missed; this is allowed.
- `period`, `period_valid` and `edge_count` update in the same cycle `tick_rise` asserts.
- `lost` asserts exactly `TIMEOUT` cycles after the last rise pulse, or after reset release if no rise has occurred.

## Structure
- Package `slow_tick_pkg` holds:
  - the state enum (WAIT_FIRST, MEASURE, LOST);
  - the default `CNT_W` and `TIMEOUT` constants.
- Sub-module `sync_ff`: a parameterised-depth, reset-to-0 flop chain, reusable by other CDC inputs.
- Edge detection, the FSM and counters live in the top level.

## Test plan
- Reset with `slow_in`=0, then toggle `slow_in` every 5 cycles. Expected:
  - first `tick_rise` 3 cycles after the first rise;
  - `period`=10 with `period_valid`=1 from the second rise on;
  - `tick_fall` between each pair of rises.
- `TIMEOUT`=50, `slow_in` held at 0 after reset. Expected: `lost`=1 exactly 50 cycles after release; `period_valid`=0.
- From LOST, restart a 10-cycle square wave. Expected:
  - `lost`=0 on the first rise pulse;
  - `period_valid` stays 0 until the second rise, where `period`=10.
- Rise aligned so detection lands on the cycle `cnt`=`TIMEOUT`-1. Expected: no `lost`; `period`=`TIMEOUT`.
- Preload 0xFFFE rises, then 2 more. Expected: `edge_count` reads 0xFFFF, then 0x0000.
- Assert `reset_in` mid-period with `slow_in`=1. Expected:
  - all outputs 0 immediately;
  - after release, one `tick_rise` at cycle 3 with `period_valid` still 0.
